// File: rtl/hwag_pkg.sv
// Shared types and helpers for the hwag angle-domain channel scheduler.
package hwag_pkg;

  localparam int unsigned ANGLE_W   = 12;
  localparam int unsigned ANGLE_MAX = 3839;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ON   = 2'd2,
    DONE = 2'd3
  } ch_state_t;

  // [on,off) membership; a window with on > off spans the 3839->0 wrap.
  function automatic logic in_window(
    input logic [ANGLE_W-1:0] a,
    input logic [ANGLE_W-1:0] on,
    input logic [ANGLE_W-1:0] off
  );
    if (on < off) begin
      return (a >= on) && (a < off);
    end else if (on > off) begin
      return (a >= on) || (a < off);
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/hwag_ch_unit.sv
// One scheduler channel: shadow/active window registers, firing FSM and
// registered ch_out/ch_fired.
module hwag_ch_unit
  import hwag_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               hwag_start,
  input  logic               angle_tick,
  input  logic [ANGLE_W-1:0] angle,
  input  logic               wrap,
  input  logic               wr,
  input  logic               wr_en,
  input  logic [ANGLE_W-1:0] wr_on,
  input  logic [ANGLE_W-1:0] wr_off,
  output logic               pend,
  output logic               ch_out,
  output logic               ch_fired
);

  logic               sh_en_q, act_en_q, pend_q;
  logic [ANGLE_W-1:0] sh_on_q, sh_off_q, act_on_q, act_off_q;
  logic               out_q, out_d, fired_q, fired_d;
  ch_state_t          state_q, state_d;

  logic               load;
  logic               en_eff;
  logic [ANGLE_W-1:0] on_eff, off_eff;
  logic               iw;

  // A pending shadow takes effect on the wrap tick itself, so the FSM
  // evaluates that tick against the freshly loaded window.
  assign load    = wrap & pend_q;
  assign en_eff  = load ? sh_en_q  : act_en_q;
  assign on_eff  = load ? sh_on_q  : act_on_q;
  assign off_eff = load ? sh_off_q : act_off_q;
  assign iw      = in_window(angle, on_eff, off_eff);

  always_comb begin
    state_d = state_q;
    fired_d = 1'b0;
    if (!hwag_start || !en_eff) begin
      state_d = IDLE;
    end else if (angle_tick) begin
      unique case (state_q)
        IDLE: if (wrap) state_d = WAIT;
        WAIT: if (iw) state_d = ON;
        ON: begin
          // Only a wrap-spanning window may stay high across the wrap.
          if (wrap ? (on_eff <= off_eff) : !iw) begin
            state_d = DONE;
            fired_d = 1'b1;
          end
        end
        DONE: if (wrap) state_d = iw ? ON : WAIT;
      endcase
    end
    out_d = (state_d == ON);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_en_q   <= 1'b0;
      sh_on_q   <= '0;
      sh_off_q  <= '0;
      act_en_q  <= 1'b0;
      act_on_q  <= '0;
      act_off_q <= '0;
      pend_q    <= 1'b0;
      state_q   <= IDLE;
      out_q     <= 1'b0;
      fired_q   <= 1'b0;
    end else begin
      if (load) begin
        act_en_q  <= sh_en_q;
        act_on_q  <= sh_on_q;
        act_off_q <= sh_off_q;
      end
      if (wr) begin
        sh_en_q  <= wr_en;
        sh_on_q  <= wr_on;
        sh_off_q <= wr_off;
        pend_q   <= 1'b1;
      end else if (wrap) begin
        pend_q <= 1'b0;
      end
      state_q <= state_d;
      out_q   <= out_d;
      fired_q <= fired_d;
    end
  end

  assign pend     = pend_q;
  assign ch_out   = out_q;
  assign ch_fired = fired_q;

endmodule

// File: rtl/hwag_ch_sched.sv
// Angle-domain output scheduler: config decode/ack, wrap detection and
// N_CH channel units.
module hwag_ch_sched #(
  parameter  int unsigned N_CH      = 4,
  parameter  int unsigned ANGLE_W   = 12,
  parameter  int unsigned ANGLE_MAX = 3839,
  localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hwag_start,
  input  logic [ANGLE_W-1:0] angle,
  input  logic               angle_tick,
  input  logic               cfg_wr,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic               cfg_en,
  input  logic [ANGLE_W-1:0] cfg_on,
  input  logic [ANGLE_W-1:0] cfg_off,
  output logic               cfg_ack,
  output logic               cfg_err,
  output logic [N_CH-1:0]    cfg_pend,
  output logic [N_CH-1:0]    ch_out,
  output logic [N_CH-1:0]    ch_fired
);

  logic [ANGLE_W-1:0] prev_q, prev_d;
  logic               ack_q, ack_d, err_q, err_d;
  logic               cfg_bad, wrap;
  logic [N_CH-1:0]    wr_sel;

  assign cfg_bad = (32'(cfg_on) > ANGLE_MAX) || (32'(cfg_off) > ANGLE_MAX) ||
                   (32'(cfg_ch) >= N_CH);
  assign wrap    = angle_tick & hwag_start & (angle < prev_q);

  always_comb begin
    prev_d = angle_tick ? angle : prev_q;
    ack_d  = cfg_wr;
    err_d  = cfg_wr & cfg_bad;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr_sel[i] = cfg_wr & ~cfg_bad & (32'(cfg_ch) == i);

    hwag_ch_unit u_unit (
      .clk        (clk),
      .rst        (rst),
      .hwag_start (hwag_start),
      .angle_tick (angle_tick),
      .angle      (angle),
      .wrap       (wrap),
      .wr         (wr_sel[i]),
      .wr_en      (cfg_en),
      .wr_on      (cfg_on),
      .wr_off     (cfg_off),
      .pend       (cfg_pend[i]),
      .ch_out     (ch_out[i]),
      .ch_fired   (ch_fired[i])
    );
  end

  assign cfg_ack = ack_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_hwag_ch_sched.sv
// Directed + randomized bench for hwag_ch_sched against a revolution-level model.
module tb_hwag_ch_sched;

  localparam int N   = 4;
  localparam int REV = 3840;

  logic        clk = 1'b0;
  logic        rst;
  logic        hwag_start;
  logic [11:0] angle;
  logic        angle_tick;
  logic        cfg_wr;
  logic [1:0]  cfg_ch;
  logic        cfg_en;
  logic [11:0] cfg_on, cfg_off;
  logic        cfg_ack, cfg_err;
  logic [N-1:0] cfg_pend, ch_out, ch_fired;

  hwag_ch_sched #(.N_CH(N), .ANGLE_W(12), .ANGLE_MAX(3839)) dut (
    .clk(clk), .rst(rst), .hwag_start(hwag_start), .angle(angle),
    .angle_tick(angle_tick), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_en(cfg_en),
    .cfg_on(cfg_on), .cfg_off(cfg_off), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .cfg_pend(cfg_pend), .ch_out(ch_out), .ch_fired(ch_fired)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cur_a = 0;
  int cnt [N];

  // Model: configuration as plain integers, channel progress as three flags.
  bit m_sen [N], m_aen [N], m_pend [N];
  int m_son [N], m_soff [N], m_aon [N], m_aoff [N];
  bit m_run [N], m_high [N], m_spent [N], m_fired [N];
  int m_prev;
  bit m_ack, m_err;

  function automatic bit m_inwin(int a, int on, int off);
    int len = (off - on + REV) % REV;
    return ((a - on + REV) % REV) < len;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_sen[c] = 0; m_aen[c] = 0; m_pend[c] = 0;
      m_son[c] = 0; m_soff[c] = 0; m_aon[c] = 0; m_aoff[c] = 0;
      m_run[c] = 0; m_high[c] = 0; m_spent[c] = 0; m_fired[c] = 0;
    end
    m_prev = 0; m_ack = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit wrap, bad, iw;
    if (!rst) begin
      model_reset();
      return;
    end
    bad  = (int'(cfg_on) > 3839) || (int'(cfg_off) > 3839) || (int'(cfg_ch) >= N);
    wrap = angle_tick && hwag_start && (int'(angle) < m_prev);
    if (angle_tick) m_prev = int'(angle);
    m_ack = cfg_wr;
    m_err = cfg_wr && bad;
    for (int c = 0; c < N; c++) begin
      if (wrap && m_pend[c]) begin
        m_aen[c] = m_sen[c]; m_aon[c] = m_son[c]; m_aoff[c] = m_soff[c];
      end
      if (wrap) m_pend[c] = 0;
      if (cfg_wr && !bad && int'(cfg_ch) == c) begin
        m_sen[c] = cfg_en; m_son[c] = int'(cfg_on); m_soff[c] = int'(cfg_off);
        m_pend[c] = 1;
      end
      m_fired[c] = 0;
      if (!hwag_start || !m_aen[c]) begin
        m_run[c] = 0; m_high[c] = 0; m_spent[c] = 0;
      end else if (angle_tick) begin
        iw = m_inwin(int'(angle), m_aon[c], m_aoff[c]);
        if (!m_run[c]) begin
          m_run[c] = wrap;
        end else if (m_high[c]) begin
          if (wrap ? !(m_aon[c] > m_aoff[c]) : !iw) begin
            m_high[c] = 0; m_spent[c] = 1; m_fired[c] = 1;
          end
        end else if (m_spent[c]) begin
          if (wrap) begin m_spent[c] = 0; m_high[c] = iw; end
        end else begin
          m_high[c] = iw;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [N-1:0] e_out, e_fired, e_pend;
    for (int c = 0; c < N; c++) begin
      e_out[c] = m_high[c]; e_fired[c] = m_fired[c]; e_pend[c] = m_pend[c];
    end
    chk("ch_out", 32'(ch_out), 32'(e_out));
    chk("ch_fired", 32'(ch_fired), 32'(e_fired));
    chk("cfg_pend", 32'(cfg_pend), 32'(e_pend));
    chk("cfg_ack", 32'(cfg_ack), 32'(m_ack));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    for (int c = 0; c < N; c++) if (ch_fired[c]) cnt[c]++;
  endtask

  task automatic clr_cnt();
    for (int c = 0; c < N; c++) cnt[c] = 0;
  endtask

  task automatic tick_wr(input int a, input bit wr, input int ch, input bit en,
                         input int on, input int off);
    repeat ($urandom_range(1, 0)) cyc();
    angle = 12'(a); angle_tick = 1'b1; cur_a = a;
    cfg_wr = wr; cfg_ch = 2'(ch); cfg_en = en; cfg_on = 12'(on); cfg_off = 12'(off);
    cyc();
    angle_tick = 1'b0; cfg_wr = 1'b0;
  endtask

  task automatic tick_at(input int a);
    tick_wr(a, 1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic wr_cfg(input int ch, input bit en, input int on, input int off);
    cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_en = en; cfg_on = 12'(on); cfg_off = 12'(off);
    cyc();
    cfg_wr = 1'b0;
  endtask

  task automatic run_to_wrap(input int lo, input int hi);
    int nxt;
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      nxt = cur_a + int'($urandom_range(hi, lo));
      if (nxt >= REV) begin nxt -= REV; done = 1; end
      tick_at(nxt);
    end
    if (!done) chk("wrap_bound", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b0; hwag_start = 1'b0; angle = '0; angle_tick = 1'b0;
    cfg_wr = 1'b0; cfg_ch = '0; cfg_en = 1'b0; cfg_on = '0; cfg_off = '0;
    model_reset();
    clr_cnt();
    #1;
    chk("reset_out", 32'(ch_out), 32'd0);
    chk("reset_pend", 32'(cfg_pend), 32'd0);
    cyc(); cyc();
    rst = 1'b1; hwag_start = 1'b1;
    cyc();

    // 1: ch0 [100,200) pending until the wrap, fires once the revolution after
    wr_cfg(0, 1'b1, 100, 200);
    chk("t1_ack", 32'(cfg_ack), 32'd1);
    chk("t1_pend", 32'(cfg_pend[0]), 32'd1);
    run_to_wrap(8, 32);
    chk("t1_pend_clr", 32'(cfg_pend[0]), 32'd0);
    clr_cnt();
    run_to_wrap(8, 32);
    chk("t1_fired_cnt", 32'(cnt[0]), 32'd1);

    // 2: ch1 window spanning the wrap
    wr_cfg(1, 1'b1, 3800, 40);
    run_to_wrap(8, 32);
    run_to_wrap(8, 32);
    clr_cnt();
    run_to_wrap(8, 32);
    chk("t2_fired_cnt", 32'(cnt[1]), 32'd1);
    clr_cnt();
    run_to_wrap(8, 32);
    chk("t2_fired_cnt2", 32'(cnt[1]), 32'd1);

    // 3: rejected write, then an empty on==off window
    wr_cfg(2, 1'b1, 3840, 10);
    chk("t3_ack", 32'(cfg_ack), 32'd1);
    chk("t3_err", 32'(cfg_err), 32'd1);
    chk("t3_pend", 32'(cfg_pend[2]), 32'd0);
    wr_cfg(2, 1'b1, 500, 500);
    chk("t3_err_ok", 32'(cfg_err), 32'd0);
    run_to_wrap(8, 32);
    clr_cnt();
    run_to_wrap(8, 32);
    chk("t3_empty_cnt", 32'(cnt[2]), 32'd0);

    // 4: forward jump out of the window while ch0 is high
    tick_at(150);
    chk("t4_on", 32'(ch_out[0]), 32'd1);
    tick_at(1000);
    chk("t4_off", 32'(ch_out[0]), 32'd0);
    chk("t4_fired", 32'(ch_fired[0]), 32'd1);
    clr_cnt();
    tick_at(1100);
    run_to_wrap(8, 32);
    chk("t4_no_refire", 32'(cnt[0]), 32'd0);

    // 5: hwag_start drops mid-pulse
    tick_at(150);
    chk("t5_on", 32'(ch_out[0]), 32'd1);
    hwag_start = 1'b0;
    clr_cnt();
    cyc();
    chk("t5_drop", 32'(ch_out[0]), 32'd0);
    chk("t5_nofire", 32'(ch_fired[0]), 32'd0);
    tick_at(160); tick_at(170);
    hwag_start = 1'b1;
    run_to_wrap(8, 32);
    chk("t5_idle_rev", 32'(cnt[0]), 32'd0);
    clr_cnt();
    run_to_wrap(8, 32);
    chk("t5_resume", 32'(cnt[0]), 32'd1);

    // 6a: asynchronous reset mid-pulse
    tick_at(150);
    chk("t6_on", 32'(ch_out[0]), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_out", 32'(ch_out), 32'd0);
    chk("t6_rst_pend", 32'(cfg_pend), 32'd0);
    model_reset();
    cyc();
    rst = 1'b1; cur_a = 0;
    cyc();

    // 6b: write in the wrap cycle applies one revolution later
    wr_cfg(0, 1'b1, 100, 200);
    run_to_wrap(8, 32);
    tick_at(3830);
    tick_wr(5, 1'b1, 0, 1'b1, 300, 400);
    chk("t6_wrap_pend", 32'(cfg_pend[0]), 32'd1);
    clr_cnt();
    run_to_wrap(8, 32);
    chk("t6_old_window", 32'(cnt[0]), 32'd1);
    chk("t6_pend_clr", 32'(cfg_pend[0]), 32'd0);
    run_to_wrap(8, 32);

    // Random mix of writes, ticks, sync loss and jumps
    for (int it = 0; it < 60; it++) begin
      int r, on, off;
      r   = int'($urandom_range(9, 0));
      on  = ($urandom_range(9, 0) == 0) ? int'($urandom_range(4095, 3840)) : int'($urandom_range(3839, 0));
      off = int'($urandom_range(3839, 0));
      if (r < 3) begin
        wr_cfg(int'($urandom_range(3, 0)), $urandom_range(3, 0) != 0, on, off);
      end else if (r < 8) begin
        repeat ($urandom_range(40, 5))
          tick_wr((cur_a + int'($urandom_range(300, 1))) % REV, $urandom_range(15, 0) == 0,
                  int'($urandom_range(3, 0)), 1'b1, on, off);
      end else if (r == 8) begin
        hwag_start = 1'b0;
        tick_at((cur_a + 50) % REV);
        cyc();
        hwag_start = 1'b1;
      end else begin
        tick_at(int'($urandom_range(3839, 0)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
